// File: rtl/character_sprite_renderer_pkg.sv
// Shared constants for the character sprite path: display ids, sprite geometry,
// palette and the procedural sprite artwork used by the ROM.
package character_sprite_renderer_pkg;

  typedef enum logic [3:0] {
    ID_IDLE_1         = 4'd0,
    ID_IDLE_2         = 4'd1,
    ID_CHARGE         = 4'd2,
    ID_JUMP_UP        = 4'd3,
    ID_JUMP_DOWN      = 4'd4,
    ID_FALL_TO_GROUND = 4'd5
  } display_id_e;

  localparam int NUM_SPRITES     = 6;
  localparam int SPRITE_SIZE_DEF = 32;

  // 4:4:4 palette; entry 0 is the transparent index and must stay black.
  localparam logic [11:0] PALETTE [16] = '{
    12'h000, 12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'h0FF, 12'hF0F, 12'hFFF,
    12'h888, 12'hC40, 12'h4C0, 12'h04C, 12'hC04, 12'h40C, 12'h0C4, 12'h444
  };

  // Artwork: diagonal bands that differ per sprite and are asymmetric in col,
  // so mirroring is visible.
  function automatic logic [3:0] sprite_pixel(input logic [2:0] id,
                                              input logic [7:0] row,
                                              input logic [7:0] col);
    return 4'(col * 8'd3 + row + {5'd0, id} * 8'd5);
  endfunction

endpackage

// File: rtl/character_sprite_renderer_rom.sv
// Sprite index storage: NUM_SPRITES x SPRITE_SIZE^2 x 4 bit, synchronous read.
module sprite_rom
  import character_sprite_renderer_pkg::*;
#(
  parameter int SPRITE_SIZE = SPRITE_SIZE_DEF,
  localparam int CW = $clog2(SPRITE_SIZE),
  localparam int AW = 3 + 2 * CW
) (
  input  logic          sys_clk,
  input  logic [AW-1:0] i_addr,
  output logic [3:0]    o_idx
);

  logic [3:0] r_idx;

  always_ff @(posedge sys_clk)
    r_idx <= sprite_pixel(i_addr[AW-1 -: 3], 8'(i_addr[2*CW-1 -: CW]), 8'(i_addr[CW-1:0]));

  assign o_idx = r_idx;

endmodule

// File: rtl/character_sprite_renderer.sv
// Three-stage sprite renderer: box test, ROM lookup, palette map. Character state
// is shadowed on frame_start and carried down the pipe with each pixel.
module character_sprite_renderer
  import character_sprite_renderer_pkg::*;
#(
  parameter int SIGNED_PHY_WIDTH = 15,
  parameter int SPRITE_SIZE      = SPRITE_SIZE_DEF,
  parameter int RGB_WIDTH        = 12
) (
  input  logic                               sys_clk,
  input  logic                               sys_rst,
  input  logic                               frame_start,
  input  logic [3:0]                         char_display_id,
  input  logic signed [SIGNED_PHY_WIDTH-1:0] char_pos_x,
  input  logic signed [SIGNED_PHY_WIDTH-1:0] char_pos_y,
  input  logic                               char_face_left,
  input  logic                               pixel_valid,
  input  logic [9:0]                         pixel_x,
  input  logic [9:0]                         pixel_y,
  output logic                               out_valid,
  output logic                               pixel_hit,
  output logic [RGB_WIDTH-1:0]               pixel_rgb,
  output logic                               id_error
);

  localparam int W      = SIGNED_PHY_WIDTH;
  localparam int CW     = $clog2(SPRITE_SIZE);
  localparam int STAGES = 3;
  localparam logic signed [W:0] SZ = (W+1)'(SPRITE_SIZE);

  logic [2:0]          r_sh_id;
  logic signed [W-1:0] r_sh_x, r_sh_y;
  logic                r_sh_face, r_id_error;
  logic [STAGES:1]     r_vld_pipe;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_sh_id    <= '0;
      r_sh_x     <= '0;
      r_sh_y     <= '0;
      r_sh_face  <= 1'b0;
      r_id_error <= 1'b0;
    end else if (frame_start) begin
      if (char_display_id > 4'(ID_FALL_TO_GROUND)) begin
        r_sh_id    <= '0;
        r_id_error <= 1'b1;
      end else begin
        r_sh_id <= char_display_id[2:0];
      end
      r_sh_x    <= char_pos_x;
      r_sh_y    <= char_pos_y;
      r_sh_face <= char_face_left;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_vld_pipe <= '0;
    else         r_vld_pipe <= {r_vld_pipe[STAGES-1:1], pixel_valid};
  end

  // S1: one extra bit keeps dx/dy from wrapping for negative positions.
  logic signed [W:0] w_dx, w_dy;
  logic              w_in_box;

  assign w_dx     = signed'({{(W+1-10){1'b0}}, pixel_x}) - signed'({r_sh_x[W-1], r_sh_x});
  assign w_dy     = signed'({{(W+1-10){1'b0}}, pixel_y}) - signed'({r_sh_y[W-1], r_sh_y});
  assign w_in_box = !w_dx[W] && (w_dx < SZ) && !w_dy[W] && (w_dy < SZ);

  logic          r1_in_box, r1_face;
  logic [2:0]    r1_id;
  logic [CW-1:0] r1_row, r1_col;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r1_in_box <= 1'b0;
      r1_face   <= 1'b0;
      r1_id     <= '0;
      r1_row    <= '0;
      r1_col    <= '0;
    end else begin
      r1_in_box <= w_in_box;
      r1_face   <= r_sh_face;
      r1_id     <= r_sh_id;
      r1_row    <= w_dy[CW-1:0];
      r1_col    <= w_dx[CW-1:0];
    end
  end

  // S2: SPRITE_SIZE-1-dx is a bitwise invert for a power-of-two edge.
  logic [CW-1:0]     w_col;
  logic [3+2*CW-1:0] w_addr;
  logic [3:0]        w_idx;
  logic              r2_in_box;

  assign w_col  = r1_face ? ~r1_col : r1_col;
  assign w_addr = {r1_id, r1_row, w_col};

  sprite_rom #(.SPRITE_SIZE(SPRITE_SIZE)) u_rom (
    .sys_clk (sys_clk),
    .i_addr  (w_addr),
    .o_idx   (w_idx)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) r2_in_box <= 1'b0;
    else         r2_in_box <= r1_in_box;
  end

  // S3: palette map.
  logic                 w_hit;
  logic                 r_hit;
  logic [RGB_WIDTH-1:0] r_rgb;

  assign w_hit = r_vld_pipe[2] && r2_in_box && (w_idx != 4'd0);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_hit <= 1'b0;
      r_rgb <= '0;
    end else begin
      r_hit <= w_hit;
      r_rgb <= w_hit ? RGB_WIDTH'(PALETTE[w_idx]) : '0;
    end
  end

  assign out_valid = r_vld_pipe[STAGES];
  assign pixel_hit = r_hit;
  assign pixel_rgb = r_rgb;
  assign id_error  = r_id_error;

endmodule

// File: tb/tb_character_sprite_renderer.sv
// Directed plus randomized bench for character_sprite_renderer against an integer model.
module tb_character_sprite_renderer;

  logic               sys_clk = 1'b0;
  logic               sys_rst, frame_start, char_face_left, pixel_valid;
  logic [3:0]         char_display_id;
  logic signed [14:0] char_pos_x, char_pos_y;
  logic [9:0]         pixel_x, pixel_y;
  logic               out_valid, pixel_hit, id_error;
  logic [11:0]        pixel_rgb;

  character_sprite_renderer dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .frame_start(frame_start),
    .char_display_id(char_display_id), .char_pos_x(char_pos_x), .char_pos_y(char_pos_y),
    .char_face_left(char_face_left), .pixel_valid(pixel_valid),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .out_valid(out_valid),
    .pixel_hit(pixel_hit), .pixel_rgb(pixel_rgb), .id_error(id_error)
  );

  always #5 sys_clk = ~sys_clk;

  localparam logic [11:0] PAL [16] = '{
    12'h000, 12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'h0FF, 12'hF0F, 12'hFFF,
    12'h888, 12'hC40, 12'h4C0, 12'h04C, 12'hC04, 12'h40C, 12'h0C4, 12'h444
  };

  int checks = 0, failures = 0;

  // model: shadowed character state and the last three sampled pixels
  int          m_id, m_x, m_y;
  bit          m_face, m_err;
  bit          hv [3];
  bit          hh [3];
  logic [11:0] hr [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // sprite art is index = (3*col + row + 5*id) mod 16 in sprite-local coordinates
  function automatic void calc(input int id, input int sx, input int sy, input bit face,
                               input int px, input int py,
                               output bit hit, output logic [11:0] rgb);
    int dx, dy, col, idx;
    dx = px - sx;
    dy = py - sy;
    hit = 0;
    rgb = 12'h000;
    if (dx >= 0 && dx < 32 && dy >= 0 && dy < 32) begin
      col = face ? 31 - dx : dx;
      idx = (col * 3 + dy + id * 5) % 16;
      if (idx != 0) begin
        hit = 1;
        rgb = PAL[idx];
      end
    end
  endfunction

  task automatic model_edge();
    if (sys_rst) begin
      m_id = 0; m_x = 0; m_y = 0; m_face = 0; m_err = 0;
      for (int i = 0; i < 3; i++) hv[i] = 0;
    end else begin
      for (int i = 2; i > 0; i--) begin
        hv[i] = hv[i-1]; hh[i] = hh[i-1]; hr[i] = hr[i-1];
      end
      hv[0] = pixel_valid;
      calc(m_id, m_x, m_y, m_face, int'(pixel_x), int'(pixel_y), hh[0], hr[0]);
      if (frame_start) begin
        if (char_display_id > 4'd5) begin
          m_id = 0; m_err = 1;
        end else m_id = int'(char_display_id);
        m_x = int'(char_pos_x);
        m_y = int'(char_pos_y);
        m_face = char_face_left;
      end
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    model_edge();
    #1;
    chk("out_valid", 32'(out_valid), 32'(hv[2]));
    if (hv[2]) begin
      chk("pixel_hit", 32'(pixel_hit), 32'(hh[2]));
      chk("pixel_rgb", 32'(pixel_rgb), 32'(hr[2]));
    end
    chk("id_error", 32'(id_error), 32'(m_err));
  endtask

  task automatic set_char(input int id, input int x, input int y, input bit face);
    char_display_id = 4'(id);
    char_pos_x = 15'(x);
    char_pos_y = 15'(y);
    char_face_left = face;
  endtask

  task automatic latch();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic pix(input int x, input int y);
    pixel_valid = 1'b1;
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    tick();
    pixel_valid = 1'b0;
  endtask

  task automatic flush();
    repeat (3) tick();
  endtask

  initial begin
    int r;
    sys_rst = 1'b1; frame_start = 1'b0; pixel_valid = 1'b0;
    pixel_x = '0; pixel_y = '0;
    set_char(0, 0, 0, 0);
    repeat (3) tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_pixel_hit", 32'(pixel_hit), 0);
    chk("rst_pixel_rgb", 32'(pixel_rgb), 0);
    chk("rst_id_error", 32'(id_error), 0);
    sys_rst = 1'b0;

    // single pixel outside the box, latency 3
    pix(500, 400);
    chk("lat_c1", 32'(out_valid), 0);
    tick();
    chk("lat_c2", 32'(out_valid), 0);
    tick();
    chk("lat_c3", 32'(out_valid), 1);
    chk("lat_hit", 32'(pixel_hit), 0);
    chk("lat_rgb", 32'(pixel_rgb), 0);
    flush();

    // box edges, with a gap in pixel_valid
    set_char(2, 100, 50, 0);
    latch();
    pix(100, 50); pix(131, 81); pix(132, 50); pix(99, 50);
    tick();
    pix(110, 60); pix(131, 50); pix(100, 82);
    flush();

    // mirror: face 1 at (0,y) vs face 0 at (31,y)
    set_char(0, 0, 0, 1);
    latch();
    for (int y = 0; y < 4; y++) begin pix(0, y); pix(31, y); end
    set_char(0, 0, 0, 0);
    latch();
    for (int y = 0; y < 4; y++) begin pix(31, y); pix(0, y); end
    flush();

    // id change without frame_start, then frame_start coincident with a pixel
    set_char(0, 100, 50, 0);
    latch();
    pix(101, 50);
    char_display_id = 4'd3;
    pix(101, 50); pix(102, 51);
    frame_start = 1'b1;
    pix(101, 50);
    frame_start = 1'b0;
    pix(101, 50); pix(102, 51);
    flush();

    // clipping at negative and far-edge positions
    set_char(0, -10, -5, 0);
    latch();
    pix(0, 0); pix(21, 26); pix(22, 0); pix(1023, 0);
    set_char(0, 630, 470, 0);
    latch();
    pix(639, 479); pix(0, 479); pix(0, 0); pix(630, 470);
    flush();

    // invalid id is sticky until reset
    set_char(9, 20, 20, 0);
    latch();
    pix(20, 20); pix(25, 30);
    flush();
    chk("id_err_set", 32'(id_error), 1);
    set_char(4, 20, 20, 0);
    latch();
    pix(20, 20);
    flush();
    chk("id_err_hold", 32'(id_error), 1);

    // reset mid-line discards in-flight pixels
    pixel_valid = 1'b1;
    pixel_x = 10'd21; pixel_y = 10'd21;
    tick(); tick();
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    pixel_valid = 1'b0;
    tick();
    chk("rst_flush1", 32'(out_valid), 0);
    tick();
    chk("rst_flush2", 32'(out_valid), 0);
    tick();
    chk("rst_flush3", 32'(out_valid), 0);
    chk("id_err_clr", 32'(id_error), 0);

    // randomized traffic around the current sprite
    for (int n = 0; n < 600; n++) begin
      sys_rst = ($urandom_range(0, 99) == 0);
      frame_start = ($urandom_range(0, 19) == 0);
      r = int'($urandom_range(0, 15));
      set_char((r > 11) ? int'($urandom_range(6, 15)) : r % 6,
               int'($urandom_range(0, 720)) - 40, int'($urandom_range(0, 540)) - 40,
               1'($urandom_range(0, 1)));
      pixel_valid = ($urandom_range(0, 3) != 0);
      r = int'($urandom_range(0, 44));
      pixel_x = 10'(m_x + r - 6);
      r = int'($urandom_range(0, 44));
      pixel_y = 10'(m_y + r - 6);
      tick();
    end
    sys_rst = 1'b0; frame_start = 1'b0; pixel_valid = 1'b0;
    flush();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/character_sprite_renderer.md
CHARACTER_SPRITE_RENDERER -- requirements
Module: character_sprite_renderer

Interface
REQ-001 The block SHALL have parameter SIGNED_PHY_WIDTH, default 15, the signed character-position width.
REQ-002 The block SHALL have parameter SPRITE_SIZE, default 32, the sprite edge length in pixels (power of 2).
REQ-003 The block SHALL have parameter RGB_WIDTH, default 12, the output colour width (4:4:4).
REQ-004 sys_clk  input  1  single clock for all logic.
REQ-005 sys_rst  input  1  reset, synchronous, active-high.
REQ-006 frame_start  input  1  one-cycle pulse at start of vertical blanking.
REQ-007 char_display_id  input  4  sprite selector: 0 IDLE_1, 1 IDLE_2, 2 CHARGE, 3 JUMP_UP, 4 JUMP_DOWN, 5 FALL_TO_GROUND.
REQ-008 char_pos_x, char_pos_y  input  SIGNED_PHY_WIDTH each, signed  sprite top-left in screen pixels.
REQ-009 char_face_left  input  1  1 = mirror the sprite horizontally.
REQ-010 pixel_valid  input  1  qualifies pixel_x/pixel_y this cycle.
REQ-011 pixel_x, pixel_y  input  10 each  unsigned scan coordinates.
REQ-012 out_valid  output  1  qualifies pixel_hit/pixel_rgb.
REQ-013 pixel_hit  output  1  1 = opaque sprite pixel at this coordinate.
REQ-014 pixel_rgb  output  RGB_WIDTH  sprite colour; 0 when pixel_hit = 0.
REQ-015 id_error  output  1  sticky flag: an out-of-range id was latched.

Function
REQ-016 On a cycle with frame_start = 1, the block SHALL latch char_display_id, char_pos_x, char_pos_y, char_face_left into shadow registers; all rendering uses shadow values only.
REQ-017 A pixel with pixel_valid = 1 in the same cycle as frame_start SHALL use the pre-latch shadow values; the new values apply from the next cycle.
REQ-018 If a latched char_display_id is > 5, the shadow id SHALL become 0 and id_error SHALL set to 1, holding until reset.
REQ-019 Pipeline, 3 stages: S1 computes dx = pixel_x - shadow_x, dy = pixel_y - shadow_y as signed SIGNED_PHY_WIDTH+1-bit values and the in-box flag (0 <= dx < SPRITE_SIZE and 0 <= dy < SPRITE_SIZE); S2 forms the ROM address {id, row, col}, col = SPRITE_SIZE-1-dx when mirrored, else dx; S3 registers the 4-bit ROM index and maps it through the palette.
REQ-020 out_valid SHALL equal pixel_valid delayed exactly 3 cycles; gaps in pixel_valid are preserved.
REQ-021 pixel_hit SHALL be 1 only if in-box and ROM index != 0 (index 0 = transparent).
REQ-022 Negative positions and sprites partially off-screen SHALL clip correctly through signed comparison, with no wrap-around of dx/dy.
REQ-023 Palette: 16 entries of RGB_WIDTH bits, constant; entry 0 SHALL be 0.

Reset
REQ-024 While sys_rst = 1 at a clock edge, out_valid, pixel_hit, pixel_rgb, id_error and all pipeline valid bits SHALL clear to 0, the shadow id to 0, shadow positions to 0, and shadow face to 0.
REQ-025 Reset mid-line SHALL discard in-flight pixels; there SHALL be no out_valid in the 3 cycles after reset deassertion unless pixel_valid is driven.

Structure
REQ-026 The display-id constants, SPRITE_SIZE default, and palette table SHALL live in the shared package, shared with the display-state selector.
REQ-027 The sprite storage SHALL be a sub-module sprite_rom (synchronous read, 1-cycle latency, 6 x SPRITE_SIZE^2 x 4-bit), instantiated in S2/S3.

Verification
REQ-028 Reset, then a single pixel_valid: out_valid is 0 for 2 cycles and asserts on the 3rd cycle; pixel_hit = 0 and pixel_rgb = 0 when outside the box.
REQ-029 With pos (100,50), id 2, face 0: pixel (100,50) -> address col 0, row 0; pixel (131,81) in-box; (132,50) and (99,50) -> pixel_hit = 0.
REQ-030 Mirror: id 0, pos (0,0), face 1: pixel (0,y) reads col 31; output equals the face-0 output at (31,y).
REQ-031 Latch timing: id changes 0 -> 3 mid-frame without frame_start: output unchanged; frame_start pulse coincident with a pixel: that pixel uses id 0, the next uses id 3.
REQ-032 Clipping: pos (-10,-5): pixel (0,0) maps to col 10, row 5; pos (630,470): pixel (639,479) in-box, with no false hit at x = 0.
REQ-033 Invalid id 9 latched: id_error = 1, renders as id 0; a later valid id keeps id_error = 1 until sys_rst.
